pipe_ctrl: RTL

Central pipeline control unit for the 5-stage RV32 core. It generates the hold and flush strobes for the PC register and the IF/ID and ID/EX pipeline registers (`fliop1`, `fliop2`), and sequences four events: load-use stalls, multi-cycle divide stalls, taken-branch/jump redirects, and external-interrupt entry. It sits beside the decode/execute stages and is the only driver of every pipeline `hold`/`flush` input.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/stall_cnt.sv | 29 ++
 rtl/pipe_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
package pipe_ctrl_pkg;

  localparam int unsigned INST_ADDR_WIDTH = 32;
  localparam logic [INST_ADDR_WIDTH-1:0] INI_INST_ADDR = 32'h0000_0000;

  // Width of the control FSM state register.
  localparam int unsigned CTRL_STATE = 2;

  typedef enum logic [CTRL_STATE-1:0] {
    CtrlRun      = 2'd0,
    CtrlDivWait  = 2'd1,
    CtrlIrqDrain = 2'd2,
    CtrlIrqJump  = 2'd3
  } ctrl_state_e;

  // Counter width able to hold max_cyc without wrapping.
  function automatic int unsigned cnt_width(input int unsigned max_cyc);
    return $clog2(max_cyc) + 1;
  endfunction

endpackage

// File: rtl/stall_cnt.sv
// Cleared, saturating cycle counter shared by the divide and interrupt-drain waits.
module stall_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Clear has priority; counting stops at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: hold/flush strobes for PC, IF/ID and ID/EX, and sequencing of
// load-use stalls, divide stalls, jump redirects and interrupt entry.
// Interrupt support is compiled in only when PIPE_CTRL_IRQ_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_MAX_CYC = 40,
  // Must fit in the counter, i.e. DRAIN_CYC <= DIV_MAX_CYC, and be at least 1.
  parameter int unsigned DRAIN_CYC   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_use_i,
  input  logic                       div_start_i,
  input  logic                       div_done_i,
  input  logic                       jump_i,
  input  logic [INST_ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                       irq_i,
  input  logic [INST_ADDR_WIDTH-1:0] irq_addr_i,
  input  logic [INST_ADDR_WIDTH-1:0] id_inst_addr_i,
  output logic                       pc_hold_o,
  output logic                       ifid_hold_o,
  output logic                       idex_hold_o,
  output logic                       ifid_flush_o,
  output logic                       idex_flush_o,
  output logic                       pc_load_o,
  output logic [INST_ADDR_WIDTH-1:0] pc_target_o,
  output logic                       irq_ack_o,
  output logic [INST_ADDR_WIDTH-1:0] irq_epc_o,
  output logic                       div_timeout_o
);

  localparam int unsigned CntW = cnt_width(DIV_MAX_CYC);
  localparam logic [CntW-1:0] DivLast = CntW'(DIV_MAX_CYC - 1);

  ctrl_state_e         r_state;
  ctrl_state_e         w_state_d;
  logic [CntW-1:0]     w_cnt;
  logic                w_cnt_run;

`ifdef PIPE_CTRL_IRQ_EN
  localparam logic [CntW-1:0] DrainLast = CntW'(DRAIN_CYC - 1);

  logic [INST_ADDR_WIDTH-1:0] r_epc;
  logic [INST_ADDR_WIDTH-1:0] w_epc_d;
`else
  logic w_unused;
  assign w_unused = ^{irq_i, irq_addr_i, id_inst_addr_i, (DRAIN_CYC != 0)};
`endif

  // Counter runs only in the two wait states; it is held at zero elsewhere so each
  // wait starts from zero.
  assign w_cnt_run = (r_state == CtrlDivWait) || (r_state == CtrlIrqDrain);

  stall_cnt #(
    .W(CntW)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_clr(!w_cnt_run),
    .i_en (w_cnt_run),
    .o_cnt(w_cnt)
  );

  // Next state, EPC update and all strobes, forced low while reset is asserted.
  always_comb begin
    w_state_d     = r_state;
`ifdef PIPE_CTRL_IRQ_EN
    w_epc_d       = r_epc;
`endif
    pc_hold_o     = 1'b0;
    ifid_hold_o   = 1'b0;
    idex_hold_o   = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    pc_load_o     = 1'b0;
    pc_target_o   = '0;
    irq_ack_o     = 1'b0;
    div_timeout_o = 1'b0;

    unique case (r_state)
      CtrlRun: begin
        if (jump_i) begin
          pc_load_o    = 1'b1;
          pc_target_o  = jump_addr_i;
          ifid_flush_o = 1'b1;
          idex_flush_o = 1'b1;
        end else if (div_start_i) begin
          pc_hold_o   = 1'b1;
          ifid_hold_o = 1'b1;
          idex_hold_o = 1'b1;
          // A single-cycle divide completes immediately and never enters the wait.
          if (!div_done_i) w_state_d = CtrlDivWait;
        end else if (ld_use_i) begin
          pc_hold_o    = 1'b1;
          ifid_hold_o  = 1'b1;
          idex_flush_o = 1'b1;
`ifdef PIPE_CTRL_IRQ_EN
        end else if (irq_i) begin
          pc_hold_o    = 1'b1;
          ifid_flush_o = 1'b1;
          idex_flush_o = 1'b1;
          w_epc_d      = id_inst_addr_i;
          w_state_d    = CtrlIrqDrain;
`endif
        end
      end
      CtrlDivWait: begin
        if (div_done_i) begin
          w_state_d = CtrlRun;
        end else if (w_cnt == DivLast) begin
          div_timeout_o = 1'b1;
          w_state_d     = CtrlRun;
        end else begin
          pc_hold_o   = 1'b1;
          ifid_hold_o = 1'b1;
          idex_hold_o = 1'b1;
        end
      end
`ifdef PIPE_CTRL_IRQ_EN
      CtrlIrqDrain: begin
        pc_hold_o    = 1'b1;
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
        // A jump that was already in EX retires; return to its target instead.
        if (jump_i) w_epc_d = jump_addr_i;
        if (w_cnt == DrainLast) w_state_d = CtrlIrqJump;
      end
      CtrlIrqJump: begin
        pc_load_o   = 1'b1;
        pc_target_o = irq_addr_i;
        irq_ack_o   = 1'b1;
        w_state_d   = CtrlRun;
      end
`endif
      default: w_state_d = CtrlRun;
    endcase

    if (!rst) begin
      pc_hold_o     = 1'b0;
      ifid_hold_o   = 1'b0;
      idex_hold_o   = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_flush_o  = 1'b0;
      pc_load_o     = 1'b0;
      pc_target_o   = '0;
      irq_ack_o     = 1'b0;
      div_timeout_o = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CtrlRun;
    end else begin
      r_state <= w_state_d;
    end
  end

`ifdef PIPE_CTRL_IRQ_EN
  // Exception return address register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_epc <= INI_INST_ADDR;
    end else begin
      r_epc <= w_epc_d;
    end
  end

  assign irq_epc_o = r_epc;
`else
  assign irq_epc_o = INI_INST_ADDR;
`endif

endmodule
